// File: rtl/tmr_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tmr_irq_pkg
// Description : Shared constants for the timer/interrupt controller. This
//               package holds the channel count, the FSM state encoding and
//               the register word indices.
// Revision    : 1.0 - initial release
// ============================================================================
package tmr_irq_pkg;

    // Number of timer channels
    localparam int c_num_ch = 4;

    // Interrupt FSM state encoding (also reported in STATUS[3:2])
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_gap  = 2'd2;

    // Register word indices (0..3 are the channel registers)
    localparam logic [2:0] c_reg_ctrl   = 3'd4;
    localparam logic [2:0] c_reg_mask   = 3'd5;
    localparam logic [2:0] c_reg_pend   = 3'd6;
    localparam logic [2:0] c_reg_status = 3'd7;

endpackage
`default_nettype wire

// File: rtl/tmr_ch.sv
`default_nettype none
// ============================================================================
// Module      : tmr_ch
// Description : Single timer channel. It holds a reload register and a
//               down-counter. A load writes both. When enabled, the counter
//               decrements, and when it reaches zero it reloads and flags a
//               zero event for that cycle.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_en           - channel enable
//               i_ld, i_ld_val - load strobe and value (reload + counter)
//               o_count        - current counter value
//               o_zero_evt     - reload event this cycle (sets PEND)
// Revision    : 1.0 - initial release
// ============================================================================
module tmr_ch #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_ld,
    input  logic [CNT_W-1:0] i_ld_val,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero_evt
);

    logic [CNT_W-1:0] r_reload;
    logic [CNT_W-1:0] r_cnt;
    logic             w_zero_evt;

    // A software load takes priority and suppresses the event for that cycle
    assign w_zero_evt = i_en && !i_ld && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reload <= '0;
            r_cnt    <= '0;
        end else if (i_ld) begin
            r_reload <= i_ld_val;
            r_cnt    <= i_ld_val;
        end else if (w_zero_evt) begin
            r_cnt    <= r_reload;
        end else if (i_en) begin
            r_cnt    <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_count    = r_cnt;
    assign o_zero_evt = w_zero_evt;

endmodule
`default_nettype wire

// File: rtl/tmr_irq_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tmr_irq_ctl
// Description : Four-channel timer with a pending/mask interrupt controller
//               and a request/acknowledge handshake FSM (IDLE->REQ->GAP).
// Ports       : clk, rst        - clock, synchronous active-high reset
//               addr, din, wr_en - register write interface
//               dout            - registered read data (one cycle after addr)
//               irq_req         - interrupt request (asserted only in REQ)
//               irq_vec         - winning channel index
//               irq_ack         - CPU acknowledge (only honoured in REQ)
// Config      : TMR_IRQ_RR_EN - round-robin arbitration when defined.
//               Lowest-index-first arbitration when undefined.
// Revision    : 1.0 - initial release
// ============================================================================
module tmr_irq_ctl
    import tmr_irq_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  addr,
    input  logic [31:0] din,
    input  logic        wr_en,
    output logic [31:0] dout,
    output logic        irq_req,
    output logic [1:0]  irq_vec,
    input  logic        irq_ack
);

    logic [3:0]       r_ctrl;
    logic [3:0]       r_mask;
    logic [3:0]       r_pend;
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [1:0]       r_vec;
    logic [31:0]      r_dout;
    logic [31:0]      w_rdata;
    logic             w_irq_req;

    logic [CNT_W-1:0] w_cnt [c_num_ch];
    logic [3:0]       w_zero;
    logic [3:0]       w_ld;
    logic [3:0]       w_w1c;
    logic [3:0]       w_ack_clr;
    logic [3:0]       w_pend_nxt;
    logic [3:0]       w_req;
    logic [1:0]       w_win;

    // ---------------------------------------------------------------- channels
    generate
        for (genvar i = 0; i < c_num_ch; i++) begin : g_ch
            assign w_ld[i] = wr_en && (addr == 3'(i));

            tmr_ch #(
                .CNT_W (CNT_W)
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .i_en       (r_ctrl[i]),
                .i_ld       (w_ld[i]),
                .i_ld_val   (din[CNT_W-1:0]),
                .o_count    (w_cnt[i]),
                .o_zero_evt (w_zero[i])
            );
        end
    endgenerate

    // ---------------------------------------------------------------- pending
    assign w_w1c      = (wr_en && (addr == c_reg_pend)) ? din[3:0] : 4'b0000;
    assign w_ack_clr  = ((r_state == c_st_req) && irq_ack) ? (4'b0001 << r_vec) : 4'b0000;
    // Hardware set is OR'd in last so it wins over any same-cycle clear
    assign w_pend_nxt = (r_pend & ~w_w1c & ~w_ack_clr) | w_zero;
    assign w_req      = r_pend & r_mask;

    // ---------------------------------------------------------------- arbiter
`ifdef TMR_IRQ_RR_EN
    logic [1:0] r_last;
    logic       w_found;

    // Search starts one past the last acknowledged channel
    always_comb begin
        w_win   = r_last + 2'd1;
        w_found = 1'b0;
        for (int k = 1; k <= c_num_ch; k++) begin
            if (!w_found && w_req[r_last + 2'(k)]) begin
                w_win   = r_last + 2'(k);
                w_found = 1'b1;
            end
        end
    end

    // Reset to the top channel so the first search begins at channel 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 2'd3;
        end else if ((r_state == c_st_req) && irq_ack) begin
            r_last <= r_vec;
        end
    end
`else
    always_comb begin
        w_win = 2'd0;
        for (int k = c_num_ch - 1; k >= 0; k--) begin
            if (w_req[k]) begin
                w_win = 2'(k);
            end
        end
    end
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_req != 4'b0000) begin
                    w_state_nxt = c_st_req;
                end
            end
            c_st_req: begin
                if (irq_ack) begin
                    w_state_nxt = c_st_gap;
                end else if (!w_pend_nxt[r_vec]) begin
                    // Software withdrew the request before it was serviced
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_gap: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_comb begin
        w_irq_req = (r_state == c_st_req);
    end

    // Winner is latched only on the IDLE->REQ transition, so it stays stable in REQ
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec <= 2'd0;
        end else if ((r_state == c_st_idle) && (w_req != 4'b0000)) begin
            r_vec <= w_win;
        end
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl <= 4'b0000;
            r_mask <= 4'b0000;
            r_pend <= 4'b0000;
        end else begin
            if (wr_en && (addr == c_reg_ctrl)) begin
                r_ctrl <= din[3:0];
            end
            if (wr_en && (addr == c_reg_mask)) begin
                r_mask <= din[3:0];
            end
            r_pend <= w_pend_nxt;
        end
    end

    // ---------------------------------------------------------------- read
    always_comb begin
        w_rdata = 32'd0;
        case (addr)
            3'd0, 3'd1, 3'd2, 3'd3: w_rdata = 32'(w_cnt[addr[1:0]]);
            c_reg_ctrl:             w_rdata = {28'd0, r_ctrl};
            c_reg_mask:             w_rdata = {28'd0, r_mask};
            c_reg_pend:             w_rdata = {28'd0, r_pend};
            c_reg_status:           w_rdata = {28'd0, r_state, r_vec};
            default:                w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= 32'd0;
        end else begin
            r_dout <= w_rdata;
        end
    end

    assign dout    = r_dout;
    assign irq_req = w_irq_req;
    assign irq_vec = r_vec;

endmodule
`default_nettype wire

// File: tb/tb_tmr_irq_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tmr_irq_ctl
// Description : Directed self-checking bench for tmr_irq_ctl. Inputs are
//               driven 1 time unit after each rising edge. Outputs are
//               sampled at the same point, so they show the state after
//               that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tmr_irq_ctl;

    logic        clk;
    logic        rst;
    logic [2:0]  addr;
    logic [31:0] din;
    logic        wr_en;
    logic [31:0] dout;
    logic        irq_req;
    logic [1:0]  irq_vec;
    logic        irq_ack;

    int n_checks;
    int n_err;

    tmr_irq_ctl #(
        .CNT_W (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .din     (din),
        .wr_en   (wr_en),
        .dout    (dout),
        .irq_req (irq_req),
        .irq_vec (irq_vec),
        .irq_ack (irq_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        addr  = a;
        din   = d;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
        addr = a;
        tick();
        check(tag, dout, exp);
    endtask

    // Global safety net so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst      = 1'b1;
        addr     = 3'd0;
        din      = 32'd0;
        wr_en    = 1'b0;
        irq_ack  = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // ---------------- reset state
        check("rst_irq_req", 32'(irq_req), 32'd0);
        check("rst_irq_vec", 32'(irq_vec), 32'd0);
        check("rst_dout", dout, 32'd0);

        // ---------------- countdown 5..0 and reload (MASK=0)
        wr(3'd0, 32'd5);
        wr(3'd4, 32'h1);
        addr = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            tick();
            check("cnt_down", dout, 32'(i));
        end
        tick();
        check("cnt_reload", dout, 32'd5);
        rd_check("pend0_set", 3'd6, 32'h1);
        check("masked_no_irq", 32'(irq_req), 32'd0);
        wr(3'd4, 32'h0);
        wr(3'd6, 32'hF);
        rd_check("pend_w1c", 3'd6, 32'h0);
        rd_check("disabled_hold_a", 3'd0, 32'd2);
        rd_check("disabled_hold_b", 3'd0, 32'd2);

        // ---------------- ch1 and ch3 fire together; lowest index wins, then ch3
        wr(3'd5, 32'hF);
        wr(3'd1, 32'd2);
        wr(3'd3, 32'd2);
        wr(3'd4, 32'hA);
        tick();
        tick();
        wr(3'd4, 32'h0);
        check("pend_visible_no_req_yet", 32'(irq_req), 32'd0);
        tick();
        check("req1_irq_req", 32'(irq_req), 32'd1);
        check("req1_irq_vec", 32'(irq_vec), 32'd1);
        addr = 3'd7;
        tick();
        check("status_req", dout, 32'h5);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("gap_irq_req", 32'(irq_req), 32'd0);
        tick();
        check("status_gap", dout, 32'h9);
        check("idle_irq_req", 32'(irq_req), 32'd0);
        tick();
        check("req3_irq_req", 32'(irq_req), 32'd1);
        check("req3_irq_vec", 32'(irq_vec), 32'd3);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        tick();
        // Acknowledge held outside REQ must not produce anything
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("empty_no_req", 32'(irq_req), 32'd0);

        // ---------------- software withdraws request for ch2
        wr(3'd2, 32'd1);
        wr(3'd4, 32'h4);
        tick();
        wr(3'd4, 32'h0);
        tick();
        check("req2_irq_req", 32'(irq_req), 32'd1);
        check("req2_irq_vec", 32'(irq_vec), 32'd2);
        wr(3'd6, 32'h4);
        check("withdraw_irq_req", 32'(irq_req), 32'd0);
        rd_check("withdraw_status_idle", 3'd7, 32'h2);
        check("withdraw_stays_low", 32'(irq_req), 32'd0);

        // ---------------- hardware set beats same-cycle W1C
        wr(3'd5, 32'h0);
        wr(3'd0, 32'd1);
        wr(3'd4, 32'h1);
        tick();
        wr(3'd6, 32'h1);
        wr(3'd4, 32'h0);
        rd_check("hw_set_wins", 3'd6, 32'h1);
        wr(3'd6, 32'hF);

        // ---------------- reload 0 fires every cycle; reset during REQ
        wr(3'd0, 32'd0);
        wr(3'd5, 32'h1);
        wr(3'd4, 32'h1);
        tick();
        tick();
        check("rz_irq_req", 32'(irq_req), 32'd1);
        check("rz_irq_vec", 32'(irq_vec), 32'd0);
        rst     = 1'b1;
        irq_ack = 1'b1;
        addr    = 3'd5;
        din     = 32'hF;
        wr_en   = 1'b1;
        tick();
        rst     = 1'b0;
        irq_ack = 1'b0;
        wr_en   = 1'b0;
        check("rst_req_irq_req", 32'(irq_req), 32'd0);
        check("rst_req_irq_vec", 32'(irq_vec), 32'd0);
        check("rst_req_dout", dout, 32'd0);
        for (int a = 0; a < 8; a++) begin
            rd_check("rst_reg_zero", 3'(a), 32'd0);
        end

`ifdef TMR_IRQ_RR_EN
        // ---------------- round-robin between two always-firing channels
        wr(3'd0, 32'd0);
        wr(3'd1, 32'd0);
        wr(3'd5, 32'h3);
        wr(3'd4, 32'h3);
        for (int k = 0; k < 4; k++) begin
            for (int t = 0; t < 8 && !irq_req; t++) begin
                tick();
            end
            check("rr_irq_req", 32'(irq_req), 32'd1);
            check("rr_irq_vec", 32'(irq_vec), 32'(k % 2));
            irq_ack = 1'b1;
            tick();
            irq_ack = 1'b0;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tmr_irq_ctl.md
TMR_IRQ_CTL -- requirements
Module: tmr_irq_ctl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: channel counter width, 8..32.
REQ-002 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-004 SHALL have port addr, input, 3: register word index.
REQ-005 SHALL have port din, input, 32: write data.
REQ-006 SHALL have port wr_en, input, 1: write strobe, one write per cycle.
REQ-007 SHALL have port dout, output, 32: registered read data for addr.
REQ-008 SHALL have port irq_req, output, 1: interrupt request to CPU.
REQ-009 SHALL have port irq_vec, output, 2: winning channel index, valid while irq_req=1.
REQ-010 SHALL have port irq_ack, input, 1: CPU acknowledge, sampled only while irq_req=1.

Function
REQ-011 SHALL contain 4 timer channels with reload register, down-counter and enable bit each.
REQ-012 SHALL map registers: 0-3 = channel i (write loads reload and counter; read returns counter), 4 = CTRL[3:0] enables, 5 = MASK[3:0], 6 = PEND[3:0] (write-1-to-clear), 7 = STATUS {28'b0, state[1:0], irq_vec}.
REQ-013 SHALL zero-extend reads above CNT_W bits and ignore written bits above CNT_W.
REQ-014 SHALL present dout one cycle after addr, regardless of wr_en.
REQ-015 SHALL per channel, in priority order: load on write; else if enabled and counter==0, reload and set PEND[i]; else if enabled, decrement by 1.
REQ-016 SHALL hold a disabled channel's counter unchanged and never set its PEND bit.
REQ-017 SHALL, with reload 0 and channel enabled, set PEND[i] every cycle.
REQ-018 SHALL let a hardware PEND set win over a same-cycle software W1C of the same bit.
REQ-019 SHALL run FSM IDLE->REQ->GAP->IDLE: IDLE to REQ when (PEND & MASK)!=0, latching the winner into irq_vec.
REQ-020 SHALL drive irq_req=1 only in REQ, with irq_vec held constant throughout REQ.
REQ-021 SHALL, in REQ on irq_ack=1, clear PEND[irq_vec] and go to GAP; GAP lasts exactly one cycle with irq_req=0.
REQ-022 SHALL, in REQ, go to IDLE without ack if PEND[irq_vec] is cleared by software.
REQ-023 SHALL not abort REQ on a MASK change.
REQ-024 SHALL ignore irq_ack outside REQ.
REQ-025 SHALL give request latency of exactly 1 cycle: irq_req rises on the edge after the PEND bit becomes visible and unmasked.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, zero all counters, reloads, CTRL, MASK, PEND, dout, irq_vec and state (IDLE), giving irq_req=0.
REQ-027 SHALL let rst override any same-cycle write or irq_ack, including during REQ.

Configuration
REQ-028 SHALL, with TMR_IRQ_RR_EN defined, pick the winner round-robin, starting the search one past the last acknowledged channel (starting at channel 0 after reset).
REQ-029 SHALL, with TMR_IRQ_RR_EN undefined, pick the lowest-index pending unmasked channel as the winner.

Structure
REQ-030 SHALL place FSM state encoding and register index constants in a shared package tmr_irq_pkg.
REQ-031 SHALL implement each channel as sub-module tmr_ch, instantiated 4 times, with outputs counter and zero-event.

Verification
REQ-032 SHALL cover: write 5 to reg 0, write 1 to CTRL -> counter reads 5,4,...,0; PEND[0]=1 on the cycle after counter==0; counter reloads to 5.
REQ-033 SHALL cover: MASK=0xF, PEND bits 1 and 3 set together -> irq_vec=1; after ack, one GAP cycle, then irq_req=1 with irq_vec=3.
REQ-034 SHALL cover, with TMR_IRQ_RR_EN defined: channels 0 and 1 firing continuously -> irq_vec alternates 0,1,0,1.
REQ-035 SHALL cover: in REQ with irq_vec=2, write 0x4 to PEND -> irq_req=0 next cycle, no ack required, state IDLE.
REQ-036 SHALL cover: hardware event on channel 0 and W1C 0x1 in the same cycle -> PEND[0]=1.
REQ-037 SHALL cover: rst asserted during REQ -> irq_req=0, STATUS=0 and all registers read 0 after the edge.
